// File: rtl/byteswap_stream.sv
// Byte-reordering stream engine: latches a mode and beat count on start, permutes
// each accepted beat within 1/2/4/8-byte groups and streams it out through two register stages.
module byteswap_stream #(
    parameter int C_DATA_WIDTH  = 512,
    parameter int C_COUNT_WIDTH = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     ap_start,
    input  logic [1:0]               cfg_mode,
    input  logic [C_COUNT_WIDTH-1:0] xfer_words,
    output logic                     ap_idle,
    output logic                     ap_done,
    output logic [C_COUNT_WIDTH-1:0] beats_out,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [C_DATA_WIDTH-1:0]  s_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [C_DATA_WIDTH-1:0]  m_tdata,
    output logic                     m_tlast
);

    localparam int NB = C_DATA_WIDTH / 8;
    localparam logic [C_COUNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state, state_next;
    logic [1:0]                mode_q;
    logic [C_COUNT_WIDTH-1:0]  words_q;
    logic [C_COUNT_WIDTH-1:0]  in_cnt;
    logic [C_COUNT_WIDTH-1:0]  out_cnt;
    logic                      s1_valid, s1_last;
    logic [C_DATA_WIDTH-1:0]   s1_data;
    logic                      s2_valid, s2_last;
    logic [C_DATA_WIDTH-1:0]   s2_data;
    logic                      s1_ready, s2_ready;
    logic                      in_fire, out_fire, start_fire;
    logic [2:0]                grp_mask;
    logic [C_DATA_WIDTH-1:0]   permuted;

    assign s2_ready   = !s2_valid || m_tready;
    assign s1_ready   = !s1_valid || s2_ready;
    assign s_tready   = (state == RUN) && (in_cnt < words_q) && s1_ready;
    assign in_fire    = s_tvalid && s_tready;
    assign out_fire   = s2_valid && m_tready;
    assign start_fire = (state == IDLE) && ap_start;

    assign ap_idle   = (state == IDLE);
    assign ap_done   = (state == DONE);
    assign beats_out = out_cnt;
    assign m_tvalid  = s2_valid;
    assign m_tdata   = s2_data;
    assign m_tlast   = s2_last;

    // Group sizes are powers of two, so the in-group byte reversal is an XOR of the byte index.
    always_comb begin
        grp_mask = 3'd0;
        case (mode_q)
            2'd1:    grp_mask = 3'd1;
            2'd2:    grp_mask = 3'd3;
            2'd3:    grp_mask = 3'd7;
            default: grp_mask = 3'd0;
        endcase
        permuted = '0;
        for (int i = 0; i < NB; i++) begin
            permuted[8*i +: 8] = s_tdata[8*(i ^ int'(grp_mask)) +: 8];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ap_start) begin
                    state_next = (xfer_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (out_fire && s2_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mode_q   <= 2'd0;
            words_q  <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
        end else begin
            if (start_fire) begin
                mode_q  <= cfg_mode;
                words_q <= xfer_words;
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (in_fire) begin
                    in_cnt <= in_cnt + CNT_ONE;
                end
                if (out_fire) begin
                    out_cnt <= out_cnt + CNT_ONE;
                end
            end

            // Stage 1 only refills when its current beat has moved to stage 2 (or it was empty).
            if (s1_ready) begin
                s1_valid <= in_fire;
                if (in_fire) begin
                    s1_data <= permuted;
                    s1_last <= (in_cnt == words_q - CNT_ONE);
                end
            end

            if (s2_ready) begin
                s2_valid <= s1_valid;
                s2_last  <= s1_valid && s1_last;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end
    end

endmodule
